demux14_stream: RTL
===================

Name: demux14_stream

Overview:
- Inverse of the team's 4-to-1 selector. Takes one stream of W-bit words, each tagged with a 2-bit select, and steers each word to one of four output channels.
- Each channel has its own 2-entry FIFO. A stalled channel blocks only words addressed to it.
- Per-channel wrap-around transfer counters support debug readout on nvboard.
- Sits between a single producer and four independent consumers.

Parameters:
- W, 2, data width of each word (the select-mux data width).
- CNT_W, 8, width of each per-channel delivered-word counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer presents in_data/in_sel.
- in_ready  output  1  block accepts the word this cycle.
- in_data  input  W  word to route.
- in_sel  input  2  destination channel 0..3.
- out_valid  output  4  bit k: channel k FIFO non-empty.
- out_ready  input  4  bit k: consumer k takes the head word.
- out_data  output  4*W  slice [k*W +: W] = head word of channel k.
- out_cnt  output  4*CNT_W  slice [k*CNT_W +: CNT_W] = words delivered on channel k.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All four FIFOs empty (read/write pointers and occupancy cleared).
  - out_valid=4'b0, out_data=0, out_cnt=0.
  - Reset has priority over any push or pop in the same cycle.
  - Reset mid-operation discards buffered words; nothing is emitted afterwards.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready at a clk edge.
  - Output transfer on channel k occurs when out_valid[k] & out_ready[k] at a clk edge.
  - in_valid must be held stable with its data/sel until accepted; in_sel must not change while in_valid=1 and in_ready=0.
- in_ready = ~full[in_sel], combinational from in_sel and registered occupancy only.
  - in_ready must not depend on out_ready: no pass-through into a full FIFO.
  - in_ready is defined regardless of in_valid.
- FIFO per channel:
  - Depth 2, occupancy counter 0..2.
  - full when occupancy = 2; empty when occupancy = 0.
  - out_valid[k] = (occupancy_k != 0), registered.
  - out_data slice k = entry at read pointer; value is don't-care when empty, but must be 0 after reset.
  - Pointers are 1-bit and wrap 1->0.
- Latency:
  - A word accepted at edge N is visible on out_data/out_valid of its channel after edge N, i.e. in cycle N+1.
  - Minimum latency is 1 cycle; there is no combinational input-to-output path.
- Simultaneous events:
  - Push and pop on the same channel in the same cycle: occupancy unchanged. Legal only when not full, because in_ready blocks a push when full.
  - Push to channel j and pop on channel k (j≠k) are independent.
  - All four channels may pop in the same cycle.
- Ordering: words on each channel leave in acceptance order. There is no ordering guarantee across channels.
- Counters: out_cnt slice k increments by 1 on every output transfer on channel k. It wraps (2^CNT_W − 1) -> 0 silently and has no saturation.
- Throughput: one word per cycle sustained into any channel whose consumer holds out_ready=1.

Test Plan:
1. Reset, then in_valid=1, in_sel=2, in_data=2'b11, out_ready=4'b0.
   - Next cycle: out_valid=4'b0100 and slice 2 = 2'b11.
   - Push a second word to channel 2, then a third: in_ready=0 while in_sel=2.
   - Switching in_sel=0 raises in_ready=1.
2. Stream 8 words 0,1,2,3,0,1,2,3 to channel 1 with out_ready[1]=1 constantly.
   - in_ready stays 1.
   - Channel 1 emits the same sequence with 1-cycle latency.
   - out_cnt slice 1 ends at 8.
3. Fill channel 3 (2 words, out_ready=0), then set out_ready[3]=1 while pushing to channel 3.
   - in_ready=0 on the first cycle (full, no pass-through).
   - Next cycle in_ready=1; order is preserved.
4. Load one word into each channel (in_sel 0..3, data 0..3), then out_ready=4'b1111 for one cycle.
   - All four transfer in that cycle; out_valid -> 4'b0; each out_cnt slice = 1.
5. With channels 0 and 2 holding 2 words each, assert rst for 1 cycle together with in_valid=1 and out_ready=4'b1111.
   - After that edge: out_valid=0, all out_cnt=0, no word accepted.
   - The first subsequent push appears alone.
6. Deliver 256 words on channel 0 with CNT_W=8: out_cnt slice 0 wraps to 0; other slices stay 0.

Source files
------------

// File: rtl/demux14_stream.sv
// demux14_stream: steers a tagged word stream to one of four channels.
// Each channel has a 2-entry FIFO, so a stalled consumer blocks only the
// words addressed to it. Each channel also has a wrap-around counter of
// delivered words for debug readout.
module demux14_stream #(
    parameter int W     = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic [1:0]         in_sel,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*W-1:0]     out_data,
    output logic [4*CNT_W-1:0] out_cnt
);

    // Per-channel FIFO storage, 1-bit pointers, occupancy and delivered counters
    logic [W-1:0]     mem_q  [4][2];
    logic [W-1:0]     mem_d  [4][2];
    logic [3:0]       wptr_q, wptr_d;
    logic [3:0]       rptr_q, rptr_d;
    logic [1:0]       occ_q  [4];
    logic [1:0]       occ_d  [4];
    logic [CNT_W-1:0] cnt_q  [4];
    logic [CNT_W-1:0] cnt_d  [4];

    logic [3:0] full;
    logic [3:0] push;
    logic [3:0] pop;

    // Handshake decode: in_ready looks only at registered occupancy, so a
    // full FIFO never accepts a word even if its consumer pops this cycle.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            full[k] = (occ_q[k] == 2'd2);
        end
        in_ready = ~full[in_sel];
        for (int k = 0; k < 4; k++) begin
            push[k] = in_valid && in_ready && (in_sel == 2'(k));
            pop[k]  = (occ_q[k] != 2'd0) && out_ready[k];
        end
    end

    // Next-state for every channel FIFO and its delivered-word counter
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        cnt_d  = cnt_q;
        for (int k = 0; k < 4; k++) begin
            if (push[k]) begin
                mem_d[k][wptr_q[k]] = in_data;
                wptr_d[k]           = ~wptr_q[k];
            end
            if (pop[k]) begin
                rptr_d[k] = ~rptr_q[k];
                cnt_d[k]  = cnt_q[k] + CNT_W'(1);
            end
            case ({push[k], pop[k]})
                2'b10:   occ_d[k] = occ_q[k] + 2'd1;
                2'b01:   occ_d[k] = occ_q[k] - 2'd1;
                default: occ_d[k] = occ_q[k];
            endcase
        end
    end

    // State registers; storage is cleared too so out_data reads 0 after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int k = 0; k < 4; k++) begin
                mem_q[k][0] <= '0;
                mem_q[k][1] <= '0;
                occ_q[k]    <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
            cnt_q  <= cnt_d;
        end
    end

    // Output packing: head word, non-empty flag and counter per channel
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            out_valid[k]                = (occ_q[k] != 2'd0);
            out_data[k*W +: W]          = mem_q[k][rptr_q[k]];
            out_cnt[k*CNT_W +: CNT_W]   = cnt_q[k];
        end
    end

endmodule
